// File: rtl/lsu_dmem_port.sv
// Load/store unit port to a single-ported word memory: formats loads and builds
// byte/halfword stores with read-modify-write, flagging bad requests without touching memory.
module lsu_dmem_port #(
  parameter int DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataW,
  output logic        MemRW,
  input  logic [31:0] mem_dataB
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [29:0] LP_DEPTH = 30'(DEPTH_WORDS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wword;
  logic [31:0] r_rsp_rdata;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic        r_rsp_err;
  logic        w_accept;
  logic        w_req_err;
  logic        w_is_sw;

  function automatic logic f_req_err(input logic [31:0] addr, input logic [2:0] f3,
                                     input logic we);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr[0];
      3'b010:  bad = (addr[1:0] != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | addr[0];
      default: bad = 1'b1;
    endcase
    return bad | (addr[31:2] >= LP_DEPTH);
  endfunction

  function automatic logic [31:0] f_load_fmt(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'd0;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'd0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'd0, h};
      3'b010:  res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] f_store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] res;
    res = word;
    case (f3)
      3'b000: begin
        case (off)
          2'b00:   res[7:0]   = wdata[7:0];
          2'b01:   res[15:8]  = wdata[7:0];
          2'b10:   res[23:16] = wdata[7:0];
          2'b11:   res[31:24] = wdata[7:0];
          default: res = word;
        endcase
      end
      3'b001: begin
        if (off[1]) begin
          res[31:16] = wdata[15:0];
        end else begin
          res[15:0] = wdata[15:0];
        end
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_req_err = f_req_err(req_addr, req_funct3, req_we);
  assign w_is_sw   = req_we && (req_funct3 == 3'b010);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: full-word stores skip the read, sub-word stores read then write
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt = S_RESP;
          end else if (w_is_sw) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        if (r_we) begin
          w_state_nxt = S_WR;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_WR: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, read-word merge/format at the end of RD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= 32'd0;
      r_funct3    <= 3'd0;
      r_we        <= 1'b0;
      r_wword     <= 32'd0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr      <= req_addr;
            r_funct3    <= req_funct3;
            r_we        <= req_we;
            r_wword     <= req_wdata;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= w_req_err;
          end
        end
        S_RD: begin
          if (r_we) begin
            r_wword <= f_store_merge(mem_dataB, r_wword, r_addr[1:0], r_funct3);
          end else begin
            r_rsp_rdata <= f_load_fmt(mem_dataB, r_addr[1:0], r_funct3);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode straight from registers so reset clears them without a clock
  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = (r_state == S_RESP) ? r_rsp_rdata : 32'd0;
  assign rsp_err   = (r_state == S_RESP) ? r_rsp_err : 1'b0;
  assign mem_addr  = ((r_state == S_RD) || (r_state == S_WR)) ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_dataW = (r_state == S_WR) ? r_wword : 32'd0;
  assign MemRW     = (r_state == S_WR);

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Bench for lsu_dmem_port: behavioural 32-word memory plus a response scoreboard.
module tb_lsu_dmem_port;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_dataW;
  logic        MemRW;
  logic [31:0] mem_dataB;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks;
  int          n_fail;
  int          wr_count;
  int          addr_nz;
  logic        mem_loaded;
  logic [31:0] mem [0:31];

  lsu_dmem_port #(.DEPTH_WORDS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_dataW(mem_dataW), .MemRW(MemRW), .mem_dataB(mem_dataB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dataB = mem[mem_addr[6:2]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem[4] <= 32'h1122_3344;
    end else if (MemRW) begin
      mem[mem_addr[6:2]] <= mem_dataW;
    end
  end

  always @(posedge clk) begin
    if (MemRW) wr_count <= wr_count + 1;
    if (mem_addr != 32'd0) addr_nz <= addr_nz + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, MemRW} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b, expected 1000", {req_ready, rsp_valid, rsp_err, MemRW});
    end
    n_checks++;
    if ({rsp_rdata, mem_addr, mem_dataW} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h, expected zeros", rsp_rdata, mem_addr, mem_dataW);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_idle: got %b, expected 10", {req_ready, rsp_valid});
    end
  endtask

  task automatic test_stores();
    exp_t e;
    int   lat;
    int   w0;
    w0 = wr_count;
    e.rdata = 32'd0; e.err = 1'b0; e.lat = 3;
    sb_q.push_back(e);
    drive_req(1'b1, 3'b000, 32'h0000_0011, 32'hFFFF_FFAB);
    n_checks++;
    if ({MemRW, mem_addr} !== {1'b0, 32'h0000_0010}) begin
      n_fail++;
      $display("FAIL sb_rd: got %b %h, expected 0 00000010", MemRW, mem_addr);
    end
    tick();
    n_checks++;
    if ({MemRW, mem_dataW} !== {1'b1, 32'h1122_AB44}) begin
      n_fail++;
      $display("FAIL sb_wr: got %b %h, expected 1 1122ab44", MemRW, mem_dataW);
    end
    wait_rsp(2, lat);
    e = sb_q.pop_front();
    n_checks++;
    if ({lat, rsp_rdata, rsp_err} !== {e.lat, e.rdata, e.err}) begin
      n_fail++;
      $display("FAIL sb_rsp: got lat %0d %h %b, expected lat %0d %h %b",
               lat, rsp_rdata, rsp_err, e.lat, e.rdata, e.err);
    end
    handshake();
    n_checks++;
    if ((wr_count - w0) !== 1 || mem[4] !== 32'h1122_AB44) begin
      n_fail++;
      $display("FAIL sb_mem: got %0d writes word %h, expected 1 write word 1122ab44",
               wr_count - w0, mem[4]);
    end
    // SH upper half of word 5, then SW that seeds word 4 for the load tests
    e.lat = 3;
    sb_q.push_back(e);
    drive_req(1'b1, 3'b001, 32'h0000_0016, 32'h1234_BEEF);
    wait_rsp(1, lat);
    e = sb_q.pop_front();
    handshake();
    n_checks++;
    if (lat !== e.lat || mem[5] !== 32'hBEEF_0005) begin
      n_fail++;
      $display("FAIL sh: got lat %0d word %h, expected lat %0d word beef0005", lat, mem[5], e.lat);
    end
    e.lat = 2;
    sb_q.push_back(e);
    drive_req(1'b1, 3'b010, 32'h0000_0010, 32'h8000_00F0);
    wait_rsp(1, lat);
    e = sb_q.pop_front();
    handshake();
    n_checks++;
    if (lat !== e.lat || mem[4] !== 32'h8000_00F0) begin
      n_fail++;
      $display("FAIL sw: got lat %0d word %h, expected lat %0d word 800000f0", lat, mem[4], e.lat);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t  [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
    logic [31:0] adr_t [5] = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h10};
    logic [31:0] exp_t_[5] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'h0000_8000,
                               32'hFFFF_8000, 32'h8000_00F0};
    exp_t e;
    int   lat;
    for (int i = 0; i < 5; i++) begin
      e.rdata = exp_t_[i]; e.err = 1'b0; e.lat = 2;
      sb_q.push_back(e);
      drive_req(1'b0, f3_t[i], adr_t[i], 32'h0);
      wait_rsp(1, lat);
      e = sb_q.pop_front();
      n_checks++;
      if ({lat, rsp_rdata, rsp_err} !== {e.lat, e.rdata, e.err}) begin
        n_fail++;
        $display("FAIL load%0d: got lat %0d %h %b, expected lat %0d %h %b",
                 i, lat, rsp_rdata, rsp_err, e.lat, e.rdata, e.err);
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v [4] = '{32'hFFFF_FFF0, 32'h0, 32'h0, 32'hFFFF_FF80};
    exp_t e;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready%0d: got %b, expected 1", i, req_ready);
      end
      e.rdata = exp_v[i]; e.err = 1'b0; e.lat = 2;
      sb_q.push_back(e);
      drive_req(1'b0, 3'b000, 32'h10 + 32'(i), 32'h0);
      wait_rsp(1, lat);
      e = sb_q.pop_front();
      n_checks++;
      if ({lat, rsp_rdata} !== {e.lat, e.rdata}) begin
        n_fail++;
        $display("FAIL b2b%0d: got lat %0d %h, expected lat %0d %h", i, lat, rsp_rdata, e.lat, e.rdata);
      end
      handshake();
    end
  endtask

  task automatic test_errors();
    logic        we_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3_t  [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010, 3'b010};
    logic [31:0] adr_t [6] = '{32'h06, 32'h11, 32'h00, 32'h00, 32'h80, 32'h100};
    exp_t e;
    int   lat;
    int   w0;
    int   a0;
    for (int i = 0; i < 6; i++) begin
      w0 = wr_count;
      a0 = addr_nz;
      e.rdata = 32'd0; e.err = 1'b1; e.lat = 1;
      sb_q.push_back(e);
      drive_req(we_t[i], f3_t[i], adr_t[i], 32'h5555_AAAA);
      wait_rsp(1, lat);
      e = sb_q.pop_front();
      n_checks++;
      if ({lat, rsp_rdata, rsp_err} !== {e.lat, e.rdata, e.err}) begin
        n_fail++;
        $display("FAIL err%0d: got lat %0d %h %b, expected lat %0d %h %b",
                 i, lat, rsp_rdata, rsp_err, e.lat, e.rdata, e.err);
      end
      handshake();
      n_checks++;
      if ((wr_count - w0) !== 0 || (addr_nz - a0) !== 0) begin
        n_fail++;
        $display("FAIL err%0d_mem: got %0d writes %0d addr cycles, expected 0 0",
                 i, wr_count - w0, addr_nz - a0);
      end
    end
  endtask

  task automatic test_top_word();
    exp_t e;
    int   lat;
    int   w0;
    w0 = wr_count;
    e.rdata = 32'd0; e.err = 1'b0; e.lat = 2;
    sb_q.push_back(e);
    drive_req(1'b1, 3'b010, 32'h0000_007C, 32'hDEAD_BEEF);
    wait_rsp(1, lat);
    e = sb_q.pop_front();
    n_checks++;
    if ({lat, rsp_rdata, rsp_err} !== {e.lat, e.rdata, e.err}) begin
      n_fail++;
      $display("FAIL sw_top_rsp: got lat %0d %h %b, expected lat %0d 0 0", lat, rsp_rdata, rsp_err, e.lat);
    end
    handshake();
    n_checks++;
    if ((wr_count - w0) !== 1 || mem[31] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL sw_top_mem: got %0d writes word %h, expected 1 deadbeef", wr_count - w0, mem[31]);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int   lat;
    int   w0;
    w0 = wr_count;
    e.rdata = 32'hBEEF_0005; e.err = 1'b0; e.lat = 2;
    sb_q.push_back(e);
    drive_req(1'b0, 3'b010, 32'h0000_0014, 32'h0);
    wait_rsp(1, lat);
    e = sb_q.pop_front();
    n_checks++;
    if ({lat, rsp_rdata} !== {e.lat, e.rdata}) begin
      n_fail++;
      $display("FAIL stall_rsp: got lat %0d %h, expected lat %0d %h", lat, rsp_rdata, e.lat, e.rdata);
    end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_0018; req_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({rsp_valid, req_ready, rsp_rdata} !== {1'b1, 1'b0, e.rdata}) begin
        n_fail++;
        $display("FAIL stall%0d: got v%b r%b %h, expected v1 r0 %h", i, rsp_valid, req_ready, rsp_rdata, e.rdata);
      end
    end
    req_valid = 1'b0;
    handshake();
    tick();
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || (wr_count - w0) !== 0 || mem[6] !== 32'hA500_0006) begin
      n_fail++;
      $display("FAIL stall_ignored: got v%b %0d writes word %h, expected v0 0 a5000006",
               rsp_valid, wr_count - w0, mem[6]);
    end
  endtask

  task automatic test_reset_in_wr();
    int   w0;
    logic seen;
    w0 = wr_count;
    seen = 1'b0;
    drive_req(1'b1, 3'b010, 32'h0000_0008, 32'h1234_5678);
    n_checks++;
    if ({MemRW, mem_addr} !== {1'b1, 32'h0000_0008}) begin
      n_fail++;
      $display("FAIL rst_wr_pre: got %b %h, expected 1 00000008", MemRW, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, MemRW, rsp_rdata, mem_addr, mem_dataW} !== {4'b1000, 96'd0}) begin
      n_fail++;
      $display("FAIL rst_wr_outs: got %b %h %h %h, expected 1000 and zeros",
               {req_ready, rsp_valid, rsp_err, MemRW}, rsp_rdata, mem_addr, mem_dataW);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | rsp_valid;
    end
    n_checks++;
    if (seen !== 1'b0 || (wr_count - w0) !== 0 || mem[2] !== 32'hA500_0002 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_wr_drop: got rsp %b %0d writes word %h, expected rsp 0 0 writes a5000002",
               seen, wr_count - w0, mem[2]);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0; mem_loaded = 1'b0;
    repeat (2) @(posedge clk);
    mem_loaded = 1'b1;
    #1;
    test_reset();
    test_stores();
    test_loads();
    test_back_to_back();
    test_errors();
    test_top_word();
    test_stall();
    test_reset_in_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
